// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between an initiator and dmem_responder
//
// Signals:
//   req_valid/req_ready    request handshake
//   req_wen                1 = store, 0 = load
//   req_addr               byte address
//   req_wdata              store data, right-aligned
//   req_len                access size in bytes (1, 2, 4; anything else means 4)
//   resp_valid/resp_ready  response handshake
//   resp_rdata             load data, right-aligned, 0 for stores
//   resp_err               access faulted
// Modports: master (initiator side), slave (responder side).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_len;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_len, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_len, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency single-port data memory responder
//
// Accepts one load/store at a time, waits LATENCY cycles, performs the array
// access on the edge entering RESP and holds the response until taken.
//
// Parameters:
//   LATENCY      wait cycles between accept and response (0..15)
//   DEPTH_WORDS  storage size in 32-bit words (power of two)
//   BASE_ADDR    byte address of word 0
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          dmem_responder_if.slave request/response bus
// Build option:
//   DMEM_RESPONDER_ERR_EN  range and alignment faults reported on resp_err;
//                          when undefined, the index wraps and the address is
//                          aligned down to the access size instead.
module dmem_responder #(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT_LOAD = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [3:0]  r_cnt;
   logic        r_wen;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_len;
   logic [31:0] r_rdata;
   logic [31:0] r_mem [DEPTH_WORDS];
`ifdef DMEM_RESPONDER_ERR_EN
   logic        r_err;
`endif

   logic             w_accept;
   logic             w_enter_resp;
   logic             w_q_wen;
   logic [31:0]      w_q_addr;
   logic [31:0]      w_q_wdata;
   logic [2:0]       w_q_len;
   logic [2:0]       w_len;
   logic [31:0]      w_len_mask;
   logic [3:0]       w_be_base;
   logic [3:0]       w_be;
   logic [31:0]      w_addr;
   logic [31:0]      w_off;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_lane;
   logic             w_fault;
   logic [31:0]      w_word;
   logic [31:0]      w_wdata_sh;
   logic [31:0]      w_rdata_sh;

   assign w_accept = bus.req_valid && (r_state == S_IDLE);

   // With LATENCY=0 the access happens on the accept edge itself, before the
   // request has been latched, so the access path reads the bus while idle.
   assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd1));

   always_comb begin
      w_q_wen   = r_wen;
      w_q_addr  = r_addr;
      w_q_wdata = r_wdata;
      w_q_len   = r_len;
      if (r_state == S_IDLE) begin
         w_q_wen   = bus.req_wen;
         w_q_addr  = bus.req_addr;
         w_q_wdata = bus.req_wdata;
         w_q_len   = bus.req_len;
      end
   end

   always_comb begin
      w_len      = 3'd4;
      w_len_mask = 32'hFFFF_FFFF;
      w_be_base  = 4'b1111;
      case (w_q_len)
         3'd1: begin
            w_len      = 3'd1;
            w_len_mask = 32'h0000_00FF;
            w_be_base  = 4'b0001;
         end
         3'd2: begin
            w_len      = 3'd2;
            w_len_mask = 32'h0000_FFFF;
            w_be_base  = 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
`ifdef DMEM_RESPONDER_ERR_EN
      w_addr  = w_q_addr;
      w_off   = w_addr - BASE_ADDR;
      // Below-base addresses wrap w_off to a huge value, so they are tested
      // separately against the raw address.
      w_fault = (w_q_addr < BASE_ADDR) ||
                ({2'b00, w_off[31:2]} >= DEPTH_WORDS) ||
                ((w_len == 3'd2) && w_q_addr[0]) ||
                ((w_len == 3'd4) && (w_q_addr[1:0] != 2'b00));
`else
      case (w_len)
         3'd2:    w_addr = {w_q_addr[31:1], 1'b0};
         3'd4:    w_addr = {w_q_addr[31:2], 2'b00};
         default: w_addr = w_q_addr;
      endcase
      w_off   = w_addr - BASE_ADDR;
      w_fault = 1'b0;
`endif
   end

   // Truncating the word offset is the modulo-DEPTH_WORDS wrap.
   assign w_idx      = IDX_W'(w_off >> 2);
   assign w_lane     = w_addr[1:0];
   assign w_be       = w_be_base << w_lane;
   assign w_word     = r_mem[w_idx];
   assign w_wdata_sh = w_q_wdata << {w_lane, 3'b000};
   assign w_rdata_sh = (w_word >> {w_lane, 3'b000}) & w_len_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
`ifdef DMEM_RESPONDER_ERR_EN
      bus.resp_err   = (r_state == S_RESP) && r_err;
`else
      bus.resp_err   = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= 4'd0;
         r_wen   <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_len   <= 3'd0;
         r_rdata <= 32'h0;
`ifdef DMEM_RESPONDER_ERR_EN
         r_err   <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_wen   <= bus.req_wen;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_len   <= bus.req_len;
            r_cnt   <= LAT_LOAD;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_enter_resp) begin
            r_rdata <= (w_q_wen || w_fault) ? 32'h0 : w_rdata_sh;
`ifdef DMEM_RESPONDER_ERR_EN
            r_err   <= w_fault;
`endif
         end
      end
   end

   // Storage is never reset; rst also blocks a write racing the reset edge.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_q_wen && !w_fault && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
`timescale 1ns/1ps
module tb_dmem_responder;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          LAT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   dmem_responder #(.LATENCY(0), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   int checks = 0;
   int errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference memory as a flat byte array.
   logic [7:0] mem_b [DEPTH*4];

   task automatic model_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] len, output logic [31:0] rd, output logic err);
      int n;
      logic [31:0] a;
      logic [31:0] off;
      n   = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
      rd  = 32'h0;
      err = 1'b0;
      a   = addr;
`ifdef DMEM_RESPONDER_ERR_EN
      if (addr < BASE || ((addr - BASE) / 32'd4) >= 32'(DEPTH) || (addr % 32'(n)) != 32'd0)
         err = 1'b1;
`else
      a = addr - (addr % 32'(n));
`endif
      if (!err) begin
         off = (a - BASE) % 32'(DEPTH*4);
         for (int i = 0; i < n; i++) begin
            if (wen) mem_b[int'(off) + i] = wdata[8*i +: 8];
            else     rd[8*i +: 8] = mem_b[int'(off) + i];
         end
      end
   endtask

   // Per-cycle compare process for the LATENCY=2 instance.
   logic        pend = 1'b0;
   logic        done = 1'b0;
   int          k = 0;
   logic        m_wen;
   logic [31:0] m_addr, m_wdata, e_rd;
   logic [2:0]  m_len;
   logic        e_err;

   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
         done = 1'b0;
         check1("rst_resp_valid", bus2.resp_valid, 1'b0);
         check32("rst_resp_rdata", bus2.resp_rdata, 32'h0);
         check1("rst_resp_err", bus2.resp_err, 1'b0);
      end else begin
         if (done) begin
            pend = 1'b0;
            done = 1'b0;
         end
         if (pend) begin
            k++;
            if (k == LAT + 1) model_access(m_wen, m_addr, m_wdata, m_len, e_rd, e_err);
            check1("busy_req_ready", bus2.req_ready, 1'b0);
            check1("resp_valid_timing", bus2.resp_valid, k >= LAT + 1);
            if (k >= LAT + 1) begin
               check32("resp_rdata", bus2.resp_rdata, e_rd);
               check1("resp_err", bus2.resp_err, e_err);
               if (bus2.resp_ready) done = 1'b1;
            end else begin
               check32("wait_rdata_zero", bus2.resp_rdata, 32'h0);
               check1("wait_err_zero", bus2.resp_err, 1'b0);
            end
            if (k > 100) begin
               check1("monitor_timeout", 1'b0, 1'b1);
               pend = 1'b0;
            end
         end else begin
            check1("idle_req_ready", bus2.req_ready, 1'b1);
            check1("idle_resp_valid", bus2.resp_valid, 1'b0);
            check32("idle_rdata_zero", bus2.resp_rdata, 32'h0);
            check1("idle_err_zero", bus2.resp_err, 1'b0);
            if (bus2.req_valid) begin
               m_wen   = bus2.req_wen;
               m_addr  = bus2.req_addr;
               m_wdata = bus2.req_wdata;
               m_len   = bus2.req_len;
               pend    = 1'b1;
               k       = 0;
            end
         end
      end
   end

   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] len, input int hold,
                         output logic [31:0] rd, output logic err);
      int guard;
      int lat;
      @(posedge clk); #1;
      bus2.req_wen    = wen;
      bus2.req_addr   = addr;
      bus2.req_wdata  = wdata;
      bus2.req_len    = len;
      bus2.req_valid  = 1'b1;
      bus2.resp_ready = (hold == 0);
      guard = 0;
      @(negedge clk);
      while (!bus2.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check1("accept_seen", bus2.req_ready, 1'b1);
      @(posedge clk); #1;
      // Inputs change freely while busy; the latched request must win.
      bus2.req_valid = 1'($urandom_range(0, 1));
      bus2.req_wen   = 1'($urandom_range(0, 1));
      bus2.req_addr  = $urandom;
      bus2.req_wdata = $urandom;
      bus2.req_len   = 3'($urandom_range(0, 7));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus2.resp_valid && lat < 50);
      check32("latency", 32'(lat), 32'(LAT + 1));
      rd  = bus2.resp_rdata;
      err = bus2.resp_err;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1 bus2.resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus2.resp_ready = 1'b0;
      bus2.req_valid  = 1'b0;
   endtask

   task automatic do_req0(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] len, output logic [31:0] rd);
      @(posedge clk); #1;
      bus0.req_wen    = wen;
      bus0.req_addr   = addr;
      bus0.req_wdata  = wdata;
      bus0.req_len    = len;
      bus0.req_valid  = 1'b1;
      bus0.resp_ready = 1'b1;
      @(negedge clk);
      check1("lat0_idle_ready", bus0.req_ready, 1'b1);
      check1("lat0_idle_valid", bus0.resp_valid, 1'b0);
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      @(negedge clk);
      check1("lat0_valid_next_cycle", bus0.resp_valid, 1'b1);
      check1("lat0_busy_ready", bus0.req_ready, 1'b0);
      rd = bus0.resp_rdata;
      @(posedge clk); #1;
      bus0.resp_ready = 1'b0;
      @(negedge clk);
      check1("lat0_back_idle", bus0.req_ready, 1'b1);
      check1("lat0_valid_drop", bus0.resp_valid, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      logic [31:0] a;
      bus2.req_valid = 1'b0; bus2.req_wen = 1'b0; bus2.req_addr = 32'h0;
      bus2.req_wdata = 32'h0; bus2.req_len = 3'd4; bus2.resp_ready = 1'b0;
      bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = 32'h0;
      bus0.req_wdata = 32'h0; bus0.req_len = 3'd4; bus0.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int w = 0; w < DEPTH; w++) do_req(1'b1, BASE + 32'(4*w), $urandom, 3'd4, 0, rd, err);

      do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd4, 0, rd, err);
      check32("store_rdata_zero", rd, 32'h0);
      do_req(1'b0, 32'h8000_0010, 32'h0, 3'd4, 0, rd, err);
      check32("load_deadbeef", rd, 32'hDEAD_BEEF);
      do_req(1'b1, 32'h8000_0013, 32'h0000_005A, 3'd1, 0, rd, err);
      do_req(1'b0, 32'h8000_0010, 32'h0, 3'd4, 0, rd, err);
      check32("load_after_byte_store", rd, 32'h5AAD_BEEF);
      do_req(1'b0, 32'h8000_0013, 32'h0, 3'd1, 0, rd, err);
      check32("load_byte_lane3", rd, 32'h0000_005A);
      do_req(1'b0, 32'h8000_0012, 32'h0, 3'd2, 0, rd, err);
      check32("load_half_lane2", rd, 32'h0000_5AAD);
      do_req(1'b0, 32'h8000_0010, 32'h0, 3'd4, 5, rd, err);
      check32("held_response", rd, 32'h5AAD_BEEF);

      do_req(1'b1, 32'h8000_0020, 32'h1234_5678, 3'd4, 0, rd, err);
      @(posedge clk); #1;
      bus2.req_wen = 1'b1; bus2.req_addr = 32'h8000_0020;
      bus2.req_wdata = 32'h1111_1111; bus2.req_len = 3'd4; bus2.req_valid = 1'b1;
      @(negedge clk);
      check1("abort_accept", bus2.req_ready, 1'b1);
      @(posedge clk); #1 bus2.req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      #1 check1("rst_async_valid", bus2.resp_valid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check1("post_rst_ready", bus2.req_ready, 1'b1);
      do_req(1'b0, 32'h8000_0020, 32'h0, 3'd4, 0, rd, err);
      check32("aborted_store_no_write", rd, 32'h1234_5678);

      do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 3'd4, 0, rd, err);
      do_req(1'b0, 32'h8000_0002, 32'h0, 3'd4, 0, rd, err);
`ifdef DMEM_RESPONDER_ERR_EN
      check1("misaligned_word_err", err, 1'b1);
      check32("misaligned_word_rdata", rd, 32'h0);
`else
      check1("misaligned_word_noerr", err, 1'b0);
      check32("misaligned_word_aligned", rd, 32'hCAFE_F00D);
`endif
      do_req(1'b0, 32'h9000_0000, 32'h0, 3'd4, 0, rd, err);
`ifdef DMEM_RESPONDER_ERR_EN
      check1("out_of_range_err", err, 1'b1);
      check32("out_of_range_rdata", rd, 32'h0);
`else
      check32("wrap_index", rd, 32'hCAFE_F00D);
`endif
      do_req(1'b0, 32'h8000_0001, 32'h0, 3'd2, 0, rd, err);
`ifdef DMEM_RESPONDER_ERR_EN
      check1("misaligned_half_err", err, 1'b1);
`else
      check32("misaligned_half_aligned", rd, 32'h0000_F00D);
`endif
      do_req(1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 3'd4, 0, rd, err);
      do_req(1'b0, 32'h8000_0000, 32'h0, 3'd3, 0, rd, err);
`ifdef DMEM_RESPONDER_ERR_EN
      check32("faulted_store_suppressed", rd, 32'hCAFE_F00D);
`else
      check32("illegal_len_as_word", rd, 32'hFFFF_FFFF);
`endif

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 8) a = BASE + $urandom_range(0, DEPTH*4 - 1);
         else                          a = $urandom;
         do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), rd, err);
      end

      do_req0(1'b1, BASE + 32'd8, 32'hA5A5_1234, 3'd4, rd);
      check32("lat0_store_rdata", rd, 32'h0);
      do_req0(1'b0, BASE + 32'd8, 32'h0, 3'd4, rd);
      check32("lat0_load", rd, 32'hA5A5_1234);
      do_req0(1'b0, BASE + 32'd9, 32'h0, 3'd1, rd);
      check32("lat0_load_byte", rd, 32'h0000_0012);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have these parameters: LATENCY, 2, wait cycles between request accept and response (0..15); DEPTH_WORDS, 1024, storage size in 32-bit words (power of two); BASE_ADDR, 32'h8000_0000, byte address of word 0.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder accepts a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_len  in  3  access size in bytes: 1, 2 or 4.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  32  load data, right-aligned; 0 for stores.
- resp_err  out  1  access faulted.

Function
REQ-003 The state machine SHALL have three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-005 On accept, the module SHALL latch req_wen, req_addr, req_wdata and req_len, and load the counter with LATENCY.
REQ-006 On accept, the next state SHALL be WAIT if LATENCY > 0, otherwise RESP.
REQ-007 In WAIT, the counter SHALL decrement each cycle; the transition WAIT->RESP SHALL occur on the edge where the counter equals 1.
REQ-008 The memory access (array write or read capture) SHALL occur exactly once, on the edge entering RESP; response latency from accept edge to resp_valid=1 SHALL equal LATENCY+1 cycles.
REQ-009 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until the edge where resp_ready=1; that edge SHALL move the state to IDLE.
REQ-010 A new request SHALL NOT be accepted in the cycle that completes a response; back-to-back throughput SHALL be one request per LATENCY+2 cycles.
REQ-011 Word index SHALL be (addr - BASE_ADDR) >> 2; byte lane SHALL be addr[1:0].
REQ-012 Loads SHALL return the stored word shifted right by 8*addr[1:0], with upper bytes beyond req_len zeroed; sign extension is left to the initiator.
REQ-013 Stores SHALL write only the req_len bytes starting at lane addr[1:0], taken from the low bytes of req_wdata; other bytes SHALL be unchanged.
REQ-014 An illegal req_len value (not 1, 2 or 4) SHALL be treated as 4.
REQ-015 Outside RESP, resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-016 req_valid deasserting while the module is busy SHALL have no effect; the latched request completes.

Reset
REQ-017 rst=1 SHALL immediately force the state to IDLE, the counter to 0, req_ready=1 (once rst deasserts), and resp_valid=0, resp_rdata=0, resp_err=0.
REQ-018 Reset during WAIT SHALL abort the request with no array write; reset during RESP SHALL drop the response.
REQ-019 Array contents SHALL NOT be reset.

Configuration
REQ-020 With macro DMEM_RESPONDER_ERR_EN defined, resp_err SHALL be 1 for any of the following: an out-of-range address (index >= DEPTH_WORDS or addr < BASE_ADDR), a misaligned half-word (addr[0]=1), or a misaligned word (addr[1:0]!=0). A faulting access SHALL suppress the store, return resp_rdata=0, and keep the same timing.
REQ-021 Without DMEM_RESPONDER_ERR_EN, resp_err SHALL be constant 0. The word index SHALL wrap modulo DEPTH_WORDS, and addr SHALL be aligned down to the natural boundary of req_len before the access.

Verification
REQ-022 The bench SHALL cover the following directed scenarios, with LATENCY=2:
- Store word 0xDEADBEEF to 0x80000010, then load word from 0x80000010 -> resp_rdata=0xDEADBEEF, resp_valid on the 3rd cycle after each accept.
- After the previous step, store byte 0x5A to 0x80000013, then load word -> 0x5AADBEEF; load byte from 0x80000013 -> 0x0000005A.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1, data stable, req_ready stays 0; completes on the first cycle with resp_ready=1.
- Assert rst one cycle after accepting store 0x11111111 to 0x80000020 -> no write; a later load of that address returns the prior contents.
- With ERR_EN, load word from 0x80000002 and from 0x90000000 -> resp_err=1, resp_rdata=0. Without ERR_EN, the same load from 0x80000002 returns the word at 0x80000000.
- Parameter set LATENCY=0: load accepted -> resp_valid asserted the following cycle.
